// File: rtl/unified_mem_ctrl_if.sv
// rtl/unified_mem_ctrl_if.sv - fetch and data channel bundle for unified_mem_ctrl
interface unified_mem_ctrl_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
    input  i_ready, i_rdata, d_ready, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
    output i_ready, i_rdata, d_ready, d_rdata, d_err
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - two-port arbitrated controller over one single-port word array
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int DATA_PRIO   = 1
) (
  input  logic               clk,
  input  logic               reset,
  unified_mem_ctrl_if.slave  bus,
  output logic [3:0]         we_bram,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_i_q;      // 1: instruction port took the last grant; reset value means data-last
  logic          load;
  logic          pick_d;

  logic          gnt_d_q, we_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          cur_d, cur_we, cur_err;
  logic [1:0]    cur_size;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata, cur_rep;
  logic [3:0]    cur_strobe;
  logic          commit;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rword_q;
  logic          resp, err_q;
  logic          unused_hi_addr;

  assign unused_hi_addr = ^{bus.i_addr[31:AW+2], bus.d_addr[31:AW+2]};

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_strobe = 4'b0001 << a;
      2'b01:   lane_strobe = a[1] ? 4'b1100 : 4'b0011;
      default: lane_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Arbitration: fixed data priority, or alternate on a tie using the last-grant flag
  always_comb begin
    if (DATA_PRIO != 0) pick_d = bus.d_req;
    else                pick_d = bus.d_req & (~bus.i_req | last_i_q);
  end

  // Transaction fields: live winner while IDLE (zero-wait commit), latched copy afterwards
  always_comb begin
    if (state_q == IDLE) begin
      cur_d     = pick_d;
      cur_we    = pick_d & bus.d_we;
      cur_size  = pick_d ? bus.d_size : 2'b10;
      cur_addr  = pick_d ? bus.d_addr[AW+1:0] : bus.i_addr[AW+1:0];
      cur_wdata = bus.d_wdata;
    end else begin
      cur_d     = gnt_d_q;
      cur_we    = we_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_err    = cur_d & misaligned(cur_size, cur_addr[1:0]);
    cur_strobe = lane_strobe(cur_size, cur_addr[1:0]);
    case (cur_size)
      2'b00:   cur_rep = {4{cur_wdata[7:0]}};
      2'b01:   cur_rep = {2{cur_wdata[15:0]}};
      default: cur_rep = cur_wdata;
    endcase
  end

  // Next-state logic and wait-state counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          load = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = (state_d == RESP) && (state_q != RESP) && !reset;

  // State register and request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      last_i_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        last_i_q <= ~pick_d;
        gnt_d_q  <= pick_d;
        we_q     <= pick_d & bus.d_we;
        size_q   <= pick_d ? bus.d_size : 2'b10;
        addr_q   <= pick_d ? bus.d_addr[AW+1:0] : bus.i_addr[AW+1:0];
        wdata_q  <= bus.d_wdata;
      end
    end
  end

  // Array access on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (commit) begin
      if (cur_we && !cur_err) begin
        for (int b = 0; b < 4; b++) begin
          if (cur_strobe[b]) mem[cur_addr[AW+1:2]][8*b +: 8] <= cur_rep[8*b +: 8];
        end
      end
      rword_q <= mem[cur_addr[AW+1:2]];
    end
  end

  // Response outputs, all zero outside RESP and for the non-granted port
  always_comb begin
    resp        = (state_q == RESP);
    err_q       = gnt_d_q & misaligned(size_q, addr_q[1:0]);
    busy        = (state_q != IDLE);
    bus.i_ready = resp & ~gnt_d_q;
    bus.i_rdata = (resp && !gnt_d_q) ? rword_q : 32'h0;
    bus.d_ready = resp & gnt_d_q;
    bus.d_err   = resp & err_q;
    bus.d_rdata = 32'h0;
    we_bram     = 4'b0000;
    if (resp && gnt_d_q && !err_q) begin
      if (we_q) begin
        we_bram = lane_strobe(size_q, addr_q[1:0]);
      end else begin
        case (size_q)
          2'b00:   bus.d_rdata = {24'h0, rword_q[{addr_q[1:0], 3'b000} +: 8]};
          2'b01:   bus.d_rdata = {16'h0, addr_q[1] ? rword_q[31:16] : rword_q[15:0]};
          default: bus.d_rdata = rword_q;
        endcase
      end
    end
  end
endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the internal single-port array (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra access cycles per transaction (0..7).
REQ-003 SHALL have parameter DATA_PRIO, default 1, meaning 1 = data port wins simultaneous requests and 0 = round-robin.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have instruction port inputs i_req (1 bit) and i_addr (32 bits), and outputs i_ready (1 bit) and i_rdata (32 bits): the fetch channel, read-only and word-sized.
REQ-007 SHALL have data port inputs d_req (1), d_we (1), d_size (2, 00 byte / 01 half / 10 word), d_addr (32) and d_wdata (32), and outputs d_ready (1), d_rdata (32) and d_err (1).
REQ-008 SHALL have output we_bram, 4 bits: the byte-lane write strobe of the cycle in which a write commits, 0 otherwise.
REQ-009 SHALL have output busy, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-011 IDLE SHALL sample requests every cycle; with any request pending it SHALL latch the winner's address, size, we and wdata and go to ACCESS, or to RESP directly when WAIT_STATES=0.
REQ-012 ACCESS SHALL count WAIT_STATES cycles using a 3-bit counter loaded with WAIT_STATES-1, then go to RESP.
REQ-013 RESP SHALL last exactly one cycle: the winner's ready high, rdata valid, then back to IDLE.
REQ-014 Latency SHALL be WAIT_STATES+1 cycles from the sampling edge: request seen at edge N gives ready high in cycle N+WAIT_STATES+1.
REQ-015 Requesters SHALL hold req and their payload stable until ready; the block SHALL use only the latched copy, so later payload changes are ignored.
REQ-016 With DATA_PRIO=1, data SHALL win a simultaneous request and the losing instruction request SHALL be served in the next IDLE.
REQ-017 With DATA_PRIO=0, a 1-bit last-grant flag SHALL alternate the winner on simultaneous requests; a single requester SHALL always win.
REQ-018 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-019 Lane strobe SHALL be: byte -> 1<<addr[1:0]; half -> 0011 at addr[1]=0 and 1100 at addr[1]=1; word -> 1111.
REQ-020 A write SHALL commit on the RESP-entry edge: the selected lanes take d_wdata replicated across lanes (byte x4, half x2), and we_bram SHALL show the strobe for that cycle.
REQ-021 A data read SHALL return the selected lanes right-justified and zero-extended in d_rdata; i_rdata SHALL always be the full word.
REQ-022 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or d_size=11) SHALL write nothing, keep we_bram=0, and give d_ready=1, d_err=1 and d_rdata=0 in RESP.
REQ-023 A read following a write to the same word SHALL return the new data.
REQ-024 Non-granted ready, rdata and err SHALL be 0 in every cycle; i_ready and d_ready SHALL never both be high.

Reset
REQ-025 On reset high at an edge, the FSM SHALL go to IDLE, the counter and last-grant flag (data-last) SHALL clear, and the outputs i_ready, d_ready, d_err, we_bram and busy SHALL read 0, and i_rdata and d_rdata SHALL read 0x00000000 from the next cycle.
REQ-026 Reset in ACCESS SHALL abandon the transaction with no write committed; reset in RESP SHALL suppress that cycle's ready in the following cycle.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-028 WAIT_STATES=0: word write 0xDEADBEEF at 0x10 then word read at 0x10 -> each d_ready one cycle after req, and the read gives d_rdata=0xDEADBEEF.
REQ-029 Byte write 0xAB at 0x13 over 0x11223344 -> we_bram=1000; word read at 0x10 gives 0xAB223344; byte read at 0x13 gives 0x000000AB.
REQ-030 WAIT_STATES=3, DATA_PRIO=1, i_req and d_req raised together -> d_ready in cycle N+4, i_ready in cycle N+9, busy high throughout except the one IDLE cycle between.
REQ-031 Half write at 0x21 -> d_err=1, d_ready=1, we_bram=0000, and a word read at 0x20 returns its old value.
REQ-032 WAIT_STATES=3, reset pulsed in the second ACCESS cycle of a word write -> busy=0 and no ready next cycle, and a read-back returns the old data.
REQ-033 DATA_PRIO=0 with both requesters continuously requesting -> grants alternate I, D, I, D starting with I after reset, and address 4*DEPTH_WORDS+8 aliases word 2.
